// File: rtl/x7seg_pkg.sv
// x7seg_pkg
// Shared definitions for the seven-segment scan driver.
//   SEG_BLANK, SEG_0..SEG_F : active-low segment patterns, bit 6 = a ... bit 0 = g
//   seg_of(nibble)          : hex nibble to active-low segment pattern
//   slot_width(ndig)        : width of the digit slot counter
//   pc_width(div)           : width of the prescaler counter
package x7seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // The slot counter needs at least one bit even for the smallest bank.
    function automatic int slot_width(input int ndig);
        return (ndig > 2) ? $clog2(ndig) : 1;
    endfunction

    function automatic int pc_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/x7seg_dec.sv
// x7seg_dec
// Combinational hex nibble to active-low seven-segment decoder.
//   nib : hex digit to show
//   seg : segments a..g, msb = a, active-low
module x7seg_dec
    import x7seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = seg_of(nib);

endmodule

// File: rtl/x7seg_scan.sv
// x7seg_scan
// Time-multiplexed hex display driver for a common-anode seven-segment bank.
// A pending copy of the value is captured on ld and promoted to the displayed
// copy only at frame boundaries, so a frame never mixes old and new digits.
//
// Parameters:
//   NDIG : digits scanned (2..8)
//   DIV  : cclk cycles per digit slot (2..2^20)
// Ports:
//   cclk   : system clock, rising edge
//   clr    : asynchronous active-high reset
//   x      : value to display, nibble i drives digit i (digit 0 rightmost)
//   ld     : one-cycle strobe capturing x and dp_in
//   dp_in  : per-digit decimal point request, 1 = lit
//   blank  : 1 = blank leading zero digits (digit 0 never blanked)
//   duty   : brightness 0..15 (only when X7SEG_DIM_EN is defined)
//   a_to_g : segments a..g, msb = a, active-low
//   an     : anode enables, active-low, at most one low
//   dp     : decimal point, active-low
//   frame  : one-cycle pulse when slot 0 of a new frame is shown
//
// Optional feature macro: X7SEG_DIM_EN adds the duty port and a PWM dimmer.
module x7seg_scan
    import x7seg_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic                cclk,
    input  logic                clr,
    input  logic [4*NDIG-1:0]   x,
    input  logic                ld,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                blank,
`ifdef X7SEG_DIM_EN
    input  logic [3:0]          duty,
`endif
    output logic [6:0]          a_to_g,
    output logic [NDIG-1:0]     an,
    output logic                dp,
    output logic                frame
);

    localparam int SW  = slot_width(NDIG);
    localparam int PCW = pc_width(DIV);
    localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(NDIG - 1);

    logic [PCW-1:0]    pc;
    logic [SW-1:0]     s;
    logic [4*NDIG-1:0] pend_x;
    logic [NDIG-1:0]   pend_dp;
    logic [4*NDIG-1:0] disp_x;
    logic [NDIG-1:0]   disp_dp;

    logic              tick;
    logic              commit;
    logic [NDIG-1:0]   nz_above;
    logic [NDIG-1:0]   en;
    logic [3:0]        sel_nib;
    logic              sel_dp;
    logic              sel_en;
    logic [NDIG-1:0]   an_sel;
    logic [6:0]        seg;
    logic              lit;

    assign tick   = (pc == PC_LAST);
    assign commit = tick && (s == S_LAST);

    // Prescaler and slot counter. The slot wraps explicitly so that
    // non-power-of-two banks never visit a nonexistent digit.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            pc <= '0;
            s  <= '0;
        end else begin
            if (tick) begin
                pc <= '0;
                if (s == S_LAST) begin
                    s <= '0;
                end else begin
                    s <= s + 1'b1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Pending and displayed copies. On a coinciding ld and commit, the
    // commit sees the old pending value because both update on the same edge.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            pend_x  <= '0;
            pend_dp <= '0;
            disp_x  <= '0;
            disp_dp <= '0;
        end else begin
            if (ld) begin
                pend_x  <= x;
                pend_dp <= dp_in;
            end
            if (commit) begin
                disp_x  <= pend_x;
                disp_dp <= pend_dp;
            end
        end
    end

    // A digit stays lit if any nibble at its position or above is nonzero,
    // so only true leading zeros are blanked.
    always_comb begin
        nz_above = '0;
        nz_above[NDIG-1] = |disp_x[4*NDIG-1 -: 4];
        for (int i = NDIG - 2; i >= 0; i--) begin
            nz_above[i] = nz_above[i+1] | (|disp_x[4*i +: 4]);
        end
        en    = nz_above | {NDIG{~blank}};
        en[0] = 1'b1;
    end

    // Select everything belonging to the current slot.
    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_en  = 1'b0;
        an_sel  = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (s == SW'(i)) begin
                sel_nib   = disp_x[4*i +: 4];
                sel_dp    = disp_dp[i];
                sel_en    = en[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    x7seg_dec u_dec (
        .nib (sel_nib),
        .seg (seg)
    );

`ifdef X7SEG_DIM_EN
    logic [3:0] pw;

    // Free-running PWM phase; the anode is on for duty+1 of every 16 cycles.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            pw <= 4'd0;
        end else begin
            pw <= pw + 4'd1;
        end
    end

    assign lit = sel_en && (pw <= duty);
`else
    assign lit = sel_en;
`endif

    // Registered pin drivers. frame is raised on the same edge that first
    // drives slot 0, which is when pc and s are both back at zero.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            a_to_g <= SEG_BLANK;
            an     <= '1;
            dp     <= 1'b1;
            frame  <= 1'b0;
        end else begin
            a_to_g <= sel_en ? seg : SEG_BLANK;
            dp     <= sel_en ? ~sel_dp : 1'b1;
            an     <= lit ? an_sel : '1;
            frame  <= (pc == '0) && (s == '0);
        end
    end

endmodule

// File: tb/tb_x7seg_scan.sv
// tb_x7seg_scan
// Directed bench for x7seg_scan with NDIG = 4, DIV = 4, plus a second
// NDIG = 3, DIV = 2 instance for the non-power-of-two slot wrap.
// With X7SEG_DIM_EN defined the duty port is driven as well.
module tb_x7seg_scan;

    logic        cclk = 1'b0;
    logic        clr;
    logic [15:0] x;
    logic        ld;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  duty;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;
    logic        frame;

    logic [11:0] x3;
    logic        ld3;
    logic [2:0]  dp_in3;
    logic        blank3;
    logic [6:0]  a_to_g3;
    logic [2:0]  an3;
    logic        dp3;
    logic        frame3;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int lowCount;

    always #5 cclk = ~cclk;

    x7seg_scan #(.NDIG(4), .DIV(4)) dut (
        .cclk   (cclk),
        .clr    (clr),
        .x      (x),
        .ld     (ld),
        .dp_in  (dp_in),
        .blank  (blank),
`ifdef X7SEG_DIM_EN
        .duty   (duty),
`endif
        .a_to_g (a_to_g),
        .an     (an),
        .dp     (dp),
        .frame  (frame)
    );

    x7seg_scan #(.NDIG(3), .DIV(2)) dut3 (
        .cclk   (cclk),
        .clr    (clr),
        .x      (x3),
        .ld     (ld3),
        .dp_in  (dp_in3),
        .blank  (blank3),
`ifdef X7SEG_DIM_EN
        .duty   (duty),
`endif
        .a_to_g (a_to_g3),
        .an     (an3),
        .dp     (dp3),
        .frame  (frame3)
    );

    // k counts falling edges since the last reset release; after k falling
    // edges the outputs reflect the k-th rising edge.
    task automatic stepTo(input int target);
        while (k < target) begin
            @(negedge cclk);
            k++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present a value and pulse ld across exactly one rising edge.
    task automatic applyStimulus(input logic [15:0] xv, input logic [3:0] dpv);
        x     = xv;
        dp_in = dpv;
        ld    = 1'b1;
        stepTo(k + 1);
        ld    = 1'b0;
    endtask

    initial begin
        clr    = 1'b1;
        x      = 16'h0000;
        ld     = 1'b0;
        dp_in  = 4'b0000;
        blank  = 1'b0;
        duty   = 4'd15;
        x3     = 12'h000;
        ld3    = 1'b0;
        dp_in3 = 3'b000;
        blank3 = 1'b0;

        $display("[TB] reset hold");
        repeat (3) @(negedge cclk);
        checkOutput("rst_an", {12'h0, an}, 16'h000F);
        checkOutput("rst_seg", {9'h0, a_to_g}, 16'h007F);
        checkOutput("rst_dp", {15'h0, dp}, 16'h0001);
        checkOutput("rst_frame", {15'h0, frame}, 16'h0000);
        checkOutput("rst_an3", {13'h0, an3}, 16'h0007);

        $display("[TB] scan walk after release");
        clr = 1'b0;
        k = 0;
        stepTo(1);
        checkOutput("walk_an_s0", {12'h0, an}, 16'h000E);
        checkOutput("walk_seg_s0", {9'h0, a_to_g}, 16'h0001);
        checkOutput("walk_frame_k1", {15'h0, frame}, 16'h0001);
        checkOutput("n3_an_s0", {13'h0, an3}, 16'h0006);
        stepTo(2);
        checkOutput("walk_frame_k2", {15'h0, frame}, 16'h0000);
        stepTo(3);
        checkOutput("n3_an_s1", {13'h0, an3}, 16'h0005);
        stepTo(5);
        checkOutput("walk_an_s1", {12'h0, an}, 16'h000D);
        checkOutput("n3_an_s2", {13'h0, an3}, 16'h0003);
        stepTo(7);
        checkOutput("n3_an_wrap", {13'h0, an3}, 16'h0006);
        checkOutput("n3_frame", {15'h0, frame3}, 16'h0001);
        stepTo(9);
        checkOutput("walk_an_s2", {12'h0, an}, 16'h000B);
        stepTo(13);
        checkOutput("walk_an_s3", {12'h0, an}, 16'h0007);
        stepTo(16);
        checkOutput("walk_frame_k16", {15'h0, frame}, 16'h0000);
        stepTo(17);
        checkOutput("walk_an_wrap", {12'h0, an}, 16'h000E);
        checkOutput("walk_frame_k17", {15'h0, frame}, 16'h0001);

        $display("[TB] mid-frame load of 00A5");
        stepTo(20);
        applyStimulus(16'h00A5, 4'b0010);
        stepTo(23);
        checkOutput("hold_seg_s1", {9'h0, a_to_g}, 16'h0001);
        checkOutput("hold_an_s1", {12'h0, an}, 16'h000D);
        stepTo(30);
        blank = 1'b1;
        stepTo(33);
        checkOutput("a5_seg_s0", {9'h0, a_to_g}, 16'h0024);
        checkOutput("a5_an_s0", {12'h0, an}, 16'h000E);
        checkOutput("a5_dp_s0", {15'h0, dp}, 16'h0001);
        checkOutput("a5_frame", {15'h0, frame}, 16'h0001);
        stepTo(37);
        checkOutput("a5_seg_s1", {9'h0, a_to_g}, 16'h0008);
        checkOutput("a5_an_s1", {12'h0, an}, 16'h000D);
        checkOutput("a5_dp_s1", {15'h0, dp}, 16'h0000);
        stepTo(41);
        checkOutput("a5_an_s2_blank", {12'h0, an}, 16'h000F);
        checkOutput("a5_seg_s2_blank", {9'h0, a_to_g}, 16'h007F);
        stepTo(45);
        checkOutput("a5_an_s3_blank", {12'h0, an}, 16'h000F);
        checkOutput("a5_dp_s3_blank", {15'h0, dp}, 16'h0001);

        $display("[TB] same value without blanking");
        stepTo(50);
        blank = 1'b0;
        stepTo(57);
        checkOutput("a5_seg_s2", {9'h0, a_to_g}, 16'h0001);
        checkOutput("a5_an_s2", {12'h0, an}, 16'h000B);
        stepTo(61);
        checkOutput("a5_seg_s3", {9'h0, a_to_g}, 16'h0001);
        checkOutput("a5_an_s3", {12'h0, an}, 16'h0007);

        $display("[TB] load 1234 on the commit edge");
        stepTo(63);
        applyStimulus(16'h1234, 4'b0000);
        stepTo(65);
        checkOutput("late_old_s0", {9'h0, a_to_g}, 16'h0024);
        stepTo(69);
        checkOutput("late_old_s1", {9'h0, a_to_g}, 16'h0008);
        checkOutput("late_old_dp", {15'h0, dp}, 16'h0000);
        stepTo(81);
        checkOutput("new_seg_s0", {9'h0, a_to_g}, 16'h004C);
        checkOutput("new_frame", {15'h0, frame}, 16'h0001);
        stepTo(85);
        checkOutput("new_seg_s1", {9'h0, a_to_g}, 16'h0006);
        checkOutput("new_dp_s1", {15'h0, dp}, 16'h0001);
        stepTo(89);
        checkOutput("new_seg_s2", {9'h0, a_to_g}, 16'h0012);
        stepTo(93);
        checkOutput("new_seg_s3", {9'h0, a_to_g}, 16'h004F);
        checkOutput("new_an_s3", {12'h0, an}, 16'h0007);

        $display("[TB] reset in the middle of a frame");
        stepTo(94);
        clr = 1'b1;
        stepTo(95);
        checkOutput("midrst_an", {12'h0, an}, 16'h000F);
        checkOutput("midrst_seg", {9'h0, a_to_g}, 16'h007F);
        blank = 1'b1;
        clr = 1'b0;
        k = 0;
        stepTo(1);
        checkOutput("rel_an_s0", {12'h0, an}, 16'h000E);
        checkOutput("rel_seg_s0", {9'h0, a_to_g}, 16'h0001);
        checkOutput("rel_frame", {15'h0, frame}, 16'h0001);
        stepTo(5);
        checkOutput("rel_an_s1_blank", {12'h0, an}, 16'h000F);

`ifdef X7SEG_DIM_EN
        $display("[TB] brightness control");
        blank = 1'b0;
        duty = 4'd3;
        stepTo(k + 2);
        lowCount = 0;
        repeat (16) begin
            stepTo(k + 1);
            if (an !== 4'hF) lowCount++;
        end
        checkOutput("dim_duty3", lowCount[15:0], 16'd4);
        duty = 4'd15;
        stepTo(k + 2);
        lowCount = 0;
        repeat (16) begin
            stepTo(k + 1);
            if (an !== 4'hF) lowCount++;
        end
        checkOutput("dim_duty15", lowCount[15:0], 16'd16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
